// File: rtl/geofence_sched.sv
// Frame scheduler: round-robin grants NREQ requesters onto one geofence engine, one 6-sample frame at a time.
// Optional engine watchdog enabled by defining GEOFENCE_SCHED_TIMEOUT_EN.
module geofence_sched #(
  parameter int NREQ    = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [10*NREQ-1:0]   req_x,
  input  logic [10*NREQ-1:0]   req_y,
  input  logic [11*NREQ-1:0]   req_r,
  output logic                 eng_rst,
  output logic [9:0]           eng_x,
  output logic [9:0]           eng_y,
  output logic [10:0]          eng_r,
  input  logic                 eng_valid,
  input  logic                 eng_inside,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_inside,
  output logic                 resp_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t          state_r;
  logic [ID_W-1:0] rr_r;
  logic [ID_W-1:0] gnt_r;
  logic [2:0]      cnt_r;
  logic [2:0]      k_r;
  logic [9:0]      buf_x_r [0:5];
  logic [9:0]      buf_y_r [0:5];
  logic [10:0]     buf_r_r [0:5];

  logic            pick_found_s;
  logic [ID_W-1:0] pick_idx_s;
  logic            take_s;
  int              best_d_s;
  int              dist_s;
  logic [ID_W-1:0] gnt_next_s;
  logic            accept_s;
  logic [9:0]      sel_x_s;
  logic [9:0]      sel_y_s;
  logic [10:0]     sel_r_s;
  logic            wd_hit_s;

  // Round-robin pick: the valid requester at the smallest distance from rr_r wins
  always_comb begin
    best_d_s   = NREQ;
    dist_s     = 0;
    take_s     = 1'b0;
    pick_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      dist_s     = (i + NREQ - int'(rr_r)) % NREQ;
      take_s     = req_valid[i] && (dist_s < best_d_s);
      best_d_s   = take_s ? dist_s : best_d_s;
      pick_idx_s = take_s ? ID_W'(i) : pick_idx_s;
    end
    pick_found_s = (best_d_s < NREQ);
  end

  // Granted requester's sample lane and the next rr pointer
  always_comb begin
    sel_x_s    = req_x[int'(gnt_r)*10 +: 10];
    sel_y_s    = req_y[int'(gnt_r)*10 +: 10];
    sel_r_s    = req_r[int'(gnt_r)*11 +: 11];
    accept_s   = (state_r == LOAD) && req_valid[gnt_r] && req_ready[gnt_r];
    gnt_next_s = (int'(gnt_r) == NREQ-1) ? '0 : gnt_r + ID_W'(1);
  end

`ifdef GEOFENCE_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 1024) ? 10 : 16;
  logic [WD_W-1:0] wd_r;

  // Watchdog counts WAIT cycles; held at zero elsewhere so it starts from 0 on WAIT entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= '0;
    end else if (state_r == WAIT) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= '0;
    end
  end

  assign wd_hit_s = (state_r == WAIT) && (wd_r == WD_W'(TIMEOUT-1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
  assign wd_hit_s         = 1'b0;
`endif

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rr_r        <= '0;
      gnt_r       <= '0;
      cnt_r       <= 3'd0;
      k_r         <= 3'd0;
      req_ready   <= '0;
      eng_rst     <= 1'b1;
      eng_x       <= 10'd0;
      eng_y       <= 10'd0;
      eng_r       <= 11'd0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_inside <= 1'b0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        buf_x_r[i] <= 10'd0;
        buf_y_r[i] <= 10'd0;
        buf_r_r[i] <= 11'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            gnt_r     <= pick_idx_s;
            cnt_r     <= 3'd0;
            req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
            busy      <= 1'b1;
            state_r   <= LOAD;
          end
        end
        LOAD: begin
          if (accept_s) begin
            buf_x_r[cnt_r] <= sel_x_s;
            buf_y_r[cnt_r] <= sel_y_s;
            buf_r_r[cnt_r] <= sel_r_s;
            if (cnt_r == 3'd5) begin
              // buf[0..4] are already stable, so sample 0 can launch on the same edge
              cnt_r     <= 3'd0;
              k_r       <= 3'd0;
              req_ready <= '0;
              eng_rst   <= 1'b0;
              eng_x     <= buf_x_r[0];
              eng_y     <= buf_y_r[0];
              eng_r     <= buf_r_r[0];
              state_r   <= STREAM;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        STREAM: begin
          if (k_r == 3'd5) begin
            state_r <= WAIT;
          end else begin
            k_r   <= k_r + 3'd1;
            eng_x <= buf_x_r[k_r + 3'd1];
            eng_y <= buf_y_r[k_r + 3'd1];
            eng_r <= buf_r_r[k_r + 3'd1];
          end
        end
        WAIT: begin
          if (eng_valid) begin
            resp_valid  <= 1'b1;
            resp_id     <= gnt_r;
            resp_inside <= eng_inside;
            resp_err    <= 1'b0;
            state_r     <= RESP;
          end else if (wd_hit_s) begin
            resp_valid  <= 1'b1;
            resp_id     <= gnt_r;
            resp_inside <= 1'b0;
            resp_err    <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            eng_rst    <= 1'b1;
            rr_r       <= gnt_next_s;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          req_ready  <= '0;
          eng_rst    <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_sched.sv
// Scoreboard bench for geofence_sched: randomized frames, stub engine, round-robin reference model.
module tb_geofence_sched;

  localparam int NREQ    = 2;
  localparam int ID_W    = 1;
  localparam int TIMEOUT = 20;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [10*NREQ-1:0]  req_x;
  logic [10*NREQ-1:0]  req_y;
  logic [11*NREQ-1:0]  req_r;
  logic                eng_rst;
  logic [9:0]          eng_x;
  logic [9:0]          eng_y;
  logic [10:0]         eng_r;
  logic                eng_valid;
  logic                eng_inside;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic                resp_inside;
  logic                resp_err;
  logic                busy;

  typedef struct packed {
    logic [5:0][9:0]  x;
    logic [5:0][9:0]  y;
    logic [5:0][10:0] r;
    logic             ans;
    logic [3:0]       stall_at;
    logic [3:0]       stall_len;
  } frame_t;

  typedef struct packed {
    int     id;
    frame_t fr;
    logic   exp_inside;
    logic   exp_err;
  } exp_t;

  frame_t fq [NREQ][$];
  exp_t   sb_q [$];

  int checks     = 0;
  int failures   = 0;
  int model_rr   = 0;
  int eng_lat    = 5;
  bit no_answer  = 1'b0;
  bit stall_rand = 1'b0;
  int rdy_mode   = 1;
  int cyc        = 0;
  int cap_n      = 0;
  int cap6_cyc   = 0;

  logic       v_valid [NREQ];
  logic [9:0] dx [NREQ];
  logic [9:0] dy [NREQ];
  logic [10:0] dr [NREQ];

  geofence_sched #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_r(req_r),
    .eng_rst(eng_rst), .eng_x(eng_x), .eng_y(eng_y), .eng_r(eng_r),
    .eng_valid(eng_valid), .eng_inside(eng_inside),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_inside(resp_inside), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_r     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = v_valid[i];
      req_x[i*10 +: 10]   = dx[i];
      req_y[i*10 +: 10]   = dy[i];
      req_r[i*11 +: 11]   = dr[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int s = 0; s < 6; s++) begin
      f.x[s] = 10'($urandom);
      f.y[s] = 10'($urandom);
      f.r[s] = 11'($urandom);
    end
    f.ans       = 1'($urandom);
    f.stall_at  = 4'd0;
    f.stall_len = 4'd0;
    return f;
  endfunction

  // Reference arbiter: serve pending frames round-robin from model_rr
  task automatic predict(input logic err_mode);
    int   idx [NREQ];
    int   pick;
    bit   found;
    exp_t e;
    for (int i = 0; i < NREQ; i++) idx[i] = 0;
    while (1) begin
      found = 1'b0;
      pick  = 0;
      for (int off = 0; off < NREQ; off++) begin
        int i;
        i = (model_rr + off) % NREQ;
        if (!found && idx[i] < fq[i].size()) begin
          found = 1'b1;
          pick  = i;
        end
      end
      if (!found) break;
      e.id         = pick;
      e.fr         = fq[pick][idx[pick]];
      e.exp_inside = err_mode ? 1'b0 : e.fr.ans;
      e.exp_err    = err_mode;
      sb_q.push_back(e);
      idx[pick]++;
      model_rr = (pick + 1) % NREQ;
    end
  endtask

  task automatic wait_done(input string name);
    int  n;
    bit  pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 5000) begin
      pend = (sb_q.size() > 0);
      for (int i = 0; i < NREQ; i++) pend = pend || (fq[i].size() > 0);
      if (pend) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (pend) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Requester drivers: valid stays high until the first accept, stalls only mid-frame
  for (genvar g = 0; g < NREQ; g++) begin : g_drv
    initial begin
      frame_t fr;
      bit     acc;
      v_valid[g] = 1'b0;
      dx[g] = 10'd0;
      dy[g] = 10'd0;
      dr[g] = 11'd0;
      forever begin
        @(posedge clk); #1;
        if (reset && fq[g].size() > 0) begin
          fr = fq[g].pop_front();
          for (int s = 0; s < 6; s++) begin
            if (s > 0 && s == int'(fr.stall_at)) begin
              v_valid[g] = 1'b0;
              repeat (int'(fr.stall_len)) begin @(posedge clk); #1; end
            end else if (s > 0 && stall_rand && $urandom_range(0, 3) == 0) begin
              v_valid[g] = 1'b0;
              repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            v_valid[g] = 1'b1;
            dx[g] = fr.x[s];
            dy[g] = fr.y[s];
            dr[g] = fr.r[s];
            acc = 1'b0;
            while (!acc) begin
              @(negedge clk);
              acc = req_ready[g] && reset;
              @(posedge clk); #1;
            end
          end
          v_valid[g] = 1'b0;
        end
      end
    end
  end

  // Response-ready driver
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       resp_ready = 1'b0;
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'($urandom);
      endcase
    end
  end

  // Stub engine: captures 6 samples while out of reset, answers after eng_lat cycles
  initial begin
    int lat_cnt;
    lat_cnt    = -1;
    eng_valid  = 1'b0;
    eng_inside = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset || eng_rst) begin
        cap_n      = 0;
        lat_cnt    = -1;
        eng_valid  = reset && ($urandom_range(0, 7) == 0);
        eng_inside = 1'($urandom);
      end else begin
        eng_valid = 1'b0;
        if (cap_n < 6) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL eng_unexpected actual=stream required=idle");
          end else begin
            chk("eng_x", eng_x, sb_q[0].fr.x[cap_n]);
            chk("eng_y", eng_y, sb_q[0].fr.y[cap_n]);
            chk("eng_r", eng_r, sb_q[0].fr.r[cap_n]);
          end
          cap_n++;
          if (cap_n == 6) begin
            lat_cnt  = eng_lat;
            cap6_cyc = cyc;
          end
        end else if (lat_cnt > 0) begin
          lat_cnt--;
        end else if (lat_cnt == 0) begin
          lat_cnt = -1;
          if (!no_answer && sb_q.size() > 0) begin
            eng_valid  = 1'b1;
            eng_inside = sb_q[0].fr.ans;
          end
        end
      end
    end
  end

  // Monitor: compares presented responses with the scoreboard head, pops on handshake
  initial begin
    bit hs_prev;
    bit head_seen;
    hs_prev   = 1'b0;
    head_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        if (|req_ready) chk("eng_rst_in_load", eng_rst, 1);
        if (hs_prev) begin
          chk("post_hs_eng_rst", eng_rst, 1);
          chk("post_hs_busy", busy, 0);
          chk("post_hs_valid", resp_valid, 0);
          hs_prev = 1'b0;
        end
        if (resp_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=valid required=none id=%0d", resp_id);
          end else begin
            chk("resp_id", resp_id, sb_q[0].id);
            chk("resp_inside", resp_inside, sb_q[0].exp_inside);
            chk("resp_err", resp_err, sb_q[0].exp_err);
            chk("resp_eng_rst", eng_rst, 0);
            chk("resp_req_ready", req_ready, 0);
            chk("resp_busy", busy, 1);
            if (!head_seen && sb_q[0].exp_err) chk("timeout_latency", cyc - cap6_cyc, 21);
            head_seen = 1'b1;
            if (resp_ready) begin
              void'(sb_q.pop_front());
              hs_prev   = 1'b1;
              head_seen = 1'b0;
            end
          end
        end
      end else begin
        hs_prev   = 1'b0;
        head_seen = 1'b0;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    failures++;
    $display("FAIL global_watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    frame_t fr;
    int     n;
    int     tx [6];
    int     ty [6];
    tx = '{100, 200, 300, 300, 200, 100};
    ty = '{100, 100, 150, 250, 300, 250};

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_inside", resp_inside, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_eng_xyr", {eng_x, eng_y, eng_r}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);

    // Single directed frame from requester 0, engine answers after 40 cycles
    for (int s = 0; s < 6; s++) begin
      fr.x[s] = 10'(tx[s]);
      fr.y[s] = 10'(ty[s]);
      fr.r[s] = 11'(50 + 10*s);
    end
    fr.ans = 1'b1; fr.stall_at = 4'd0; fr.stall_len = 4'd0;
    eng_lat = 40;
    fq[0].push_back(fr);
    predict(1'b0);
    wait_done("single");

    // Requester 1 stalls for 3 cycles after its third sample
    eng_lat = 7;
    fr = rand_frame();
    fr.stall_at = 4'd3; fr.stall_len = 4'd3;
    fq[1].push_back(fr);
    predict(1'b0);
    wait_done("stall");

    // Both requesters continuously valid: grants alternate 0,1,0,1
    for (int j = 0; j < 2; j++) begin
      fq[0].push_back(rand_frame());
      fq[1].push_back(rand_frame());
    end
    predict(1'b0);
    wait_done("round_robin");

    // Response backpressure for 10 cycles with the other requester waiting
    rdy_mode = 0;
    fq[0].push_back(rand_frame());
    fq[1].push_back(rand_frame());
    predict(1'b0);
    n = 0;
    while (!resp_valid && n < 2000) begin @(negedge clk); n++; end
    chk("bp_resp_seen", n < 2000, 1);
    repeat (10) @(negedge clk);
    rdy_mode = 1;
    wait_done("backpressure");

    // Randomized rounds
    for (int round = 0; round < 6; round++) begin
      eng_lat    = $urandom_range(0, 12);
      stall_rand = 1'b1;
      rdy_mode   = 2;
      for (int i = 0; i < NREQ; i++) begin
        repeat ($urandom_range(0, 3)) fq[i].push_back(rand_frame());
      end
      predict(1'b0);
      wait_done("random");
    end
    stall_rand = 1'b0;
    rdy_mode   = 1;

    // Reset in STREAM at k=3, then rr must be back at 0
    eng_lat = 4;
    fq[0].push_back(rand_frame());
    predict(1'b0);
    wait_done("pre_reset");
    fq[1].push_back(rand_frame());
    predict(1'b0);
    n = 0;
    while (cap_n != 3 && n < 2000) begin @(posedge clk); n++; end
    chk("rst_k3_reached", n < 2000, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_eng_rst", eng_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    sb_q.delete();
    model_rr = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    fq[0].push_back(rand_frame());
    fq[1].push_back(rand_frame());
    predict(1'b0);
    wait_done("post_reset");

`ifdef GEOFENCE_SCHED_TIMEOUT_EN
    // Engine never answers: watchdog response after TIMEOUT WAIT cycles
    no_answer = 1'b1;
    fr = rand_frame();
    fr.ans = 1'b1;
    fq[0].push_back(fr);
    predict(1'b1);
    wait_done("timeout");
    no_answer = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
